// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module   : display_scan
// Brief    : Four-digit 7-segment time-multiplexing scanner with
//            frame-synchronous double-buffered display value.
// Revision : 1.0
// ============================================================================
module display_scan #(
    parameter int DIV_COUNT = 50000,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [3:0]  n,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      p_val_q, p_val_d, a_val_q, a_val_d;
    logic [3:0]       p_dp_q, p_dp_d, a_dp_q, a_dp_d;
    logic [3:0]       p_en_q, p_en_d, a_en_q, a_en_d;
    logic             p_vld_q, p_vld_d;
    logic [3:0]       an_q, an_d, n_q, n_d;
    logic             dp_q, dp_d, frame_done_q, frame_done_d;

    logic             w_wrap, w_boundary, w_nz, w_lit_sel;
    logic [3:0]       w_blank, w_lit;

    always_comb begin
        w_wrap     = (cnt_q == c_CNT_LAST);
        w_boundary = w_wrap && (idx_q == 2'd3);
        cnt_d      = w_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = w_wrap ? idx_q + 2'd1 : idx_q;

        p_val_d = p_val_q;
        p_dp_d  = p_dp_q;
        p_en_d  = p_en_q;
        p_vld_d = p_vld_q;
        a_val_d = a_val_q;
        a_dp_d  = a_dp_q;
        a_en_d  = a_en_q;

        // A load coinciding with the boundary bypasses the pending set.
        if (w_boundary) begin
            p_vld_d = 1'b0;
            if (load) begin
                a_val_d = value;
                a_dp_d  = dp_in;
                a_en_d  = digit_en;
            end else if (p_vld_q) begin
                a_val_d = p_val_q;
                a_dp_d  = p_dp_q;
                a_en_d  = p_en_q;
            end
        end else if (load) begin
            p_val_d = value;
            p_dp_d  = dp_in;
            p_en_d  = digit_en;
            p_vld_d = 1'b1;
        end

        frame_done_d = w_boundary;

        // Outputs are built from next-state values so they line up with idx_q.
        w_nz       = 1'b0;
        w_blank    = 4'b0000;
        for (int i = 3; i >= 1; i--) begin
            w_nz       = w_nz | (a_val_d[4*i +: 4] != 4'h0);
            w_blank[i] = BLANK_LZ && !w_nz;
        end
        w_lit     = a_en_d & ~w_blank;
        w_lit_sel = w_lit[idx_d];
        an_d      = w_lit_sel ? ~(4'b0001 << idx_d) : 4'b1111;
        n_d       = a_val_d[{idx_d, 2'b00} +: 4];
        dp_d      = w_lit_sel ? a_dp_d[idx_d] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            p_val_q      <= 16'h0000;
            p_dp_q       <= 4'hF;
            p_en_q       <= 4'h0;
            p_vld_q      <= 1'b0;
            a_val_q      <= 16'h0000;
            a_dp_q       <= 4'hF;
            a_en_q       <= 4'h0;
            an_q         <= 4'b1111;
            n_q          <= 4'h0;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            p_val_q      <= p_val_d;
            p_dp_q       <= p_dp_d;
            p_en_q       <= p_en_d;
            p_vld_q      <= p_vld_d;
            a_val_q      <= a_val_d;
            a_dp_q       <= a_dp_d;
            a_en_q       <= a_en_d;
            an_q         <= an_d;
            n_q          <= n_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign n          = n_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan
// Brief    : Self-checking bench for display_scan (blanking on and off).
// Revision : 1.0
// ============================================================================
module tb_display_scan;

    localparam int D = 4;
    localparam int F = 4 * D;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in, digit_en;
    logic [3:0]  an, n, an_nb, n_nb;
    logic        dp, fd, dp_nb, fd_nb;

    always #5 clk = ~clk;

    display_scan #(.DIV_COUNT(D), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .an(an), .n(n), .dp(dp), .frame_done(fd)
    );

    display_scan #(.DIV_COUNT(D), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .an(an_nb), .n(n_nb), .dp(dp_nb), .frame_done(fd_nb)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: position within the frame plus the two register sets.
    int          pos;
    logic [15:0] m_aval, m_pval;
    logic [3:0]  m_adp, m_aen, m_pdp, m_pen;
    bit          m_pvld, m_fd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_pvld = 0; m_fd = 0;
        m_aval = 16'h0; m_adp = 4'hF; m_aen = 4'h0;
        m_pval = 16'h0; m_pdp = 4'hF; m_pen = 4'h0;
    endtask

    task automatic model_edge();
        bit bnd;
        bnd = (pos == F - 1);
        if (bnd) begin
            if (load) begin
                m_aval = value; m_adp = dp_in; m_aen = digit_en;
            end else if (m_pvld) begin
                m_aval = m_pval; m_adp = m_pdp; m_aen = m_pen;
            end
            m_pvld = 0;
        end else if (load) begin
            m_pval = value; m_pdp = dp_in; m_pen = digit_en; m_pvld = 1;
        end
        m_fd = bnd;
        pos  = (pos + 1) % F;
    endtask

    task automatic expect_out(input bit blz, output logic [3:0] an_e,
                              output logic [3:0] n_e, output logic dp_e);
        int  i;
        bit  lit;
        i    = pos / D;
        n_e  = 4'((m_aval >> (4 * i)) & 16'hF);
        lit  = m_aen[i] && !(blz && i != 0 && (m_aval >> (4 * i)) == 0);
        an_e = lit ? ~(4'b0001 << i) : 4'b1111;
        dp_e = lit ? m_adp[i] : 1'b1;
    endtask

    task automatic check_all();
        logic [3:0] a_e, n_e;
        logic       d_e;
        expect_out(1'b1, a_e, n_e, d_e);
        chk("an", 16'(an), 16'(a_e));
        chk("n", 16'(n), 16'(n_e));
        chk("dp", 16'(dp), 16'(d_e));
        chk("frame_done", 16'(fd), 16'(m_fd));
        expect_out(1'b0, a_e, n_e, d_e);
        chk("an_nb", 16'(an_nb), 16'(a_e));
        chk("n_nb", 16'(n_nb), 16'(n_e));
        chk("dp_nb", 16'(dp_nb), 16'(d_e));
        chk("frame_done_nb", 16'(fd_nb), 16'(m_fd));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_all();
        load = 1'b0;
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value = v; dp_in = d; digit_en = e; load = 1'b1;
        step();
    endtask

    task automatic run_to_boundary();
        for (int k = 0; k < F && pos != F - 1; k++) step();
    endtask

    initial begin
        logic [15:0] rv;
        reset = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'hF; digit_en = 4'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all();
        reset = 1'b0;

        // Reset asserted mid-dwell while a value is displayed.
        do_load(16'h1234, 4'hF, 4'hF);
        run(19);
        reset = 1'b1;
        #1;
        chk("rst_an", 16'(an), 16'h000F);
        chk("rst_n", 16'(n), 16'h0000);
        chk("rst_dp", 16'(dp), 16'h0001);
        chk("rst_fd", 16'(fd), 16'h0000);
        model_reset();
        step(); step();
        reset = 1'b0;
        run(2 * F);
        chk("dark_after_rst", 16'(an), 16'h000F);

        // Normal scan.
        do_load(16'h1234, 4'b1011, 4'hF);
        run_to_boundary();
        step();
        chk("scan_first_an", 16'(an), 16'h000E);
        chk("scan_first_n", 16'(n), 16'h0004);
        run(2 * F);

        // Leading-zero blanking.
        do_load(16'h0050, 4'hF, 4'hF);
        run_to_boundary();
        run(F + 1);
        do_load(16'h0000, 4'hF, 4'hF);
        run_to_boundary();
        run(F + 1);

        // Two loads in one frame: last wins.
        run_to_boundary();
        step();
        run(2);
        do_load(16'h1111, 4'hF, 4'hF);
        run(3);
        do_load(16'h2222, 4'hF, 4'hF);
        run_to_boundary();
        run(F + 1);

        // Load exactly in the boundary cycle.
        run_to_boundary();
        do_load(16'h9876, 4'hF, 4'hF);
        chk("bnd_load_an", 16'(an), 16'h000E);
        chk("bnd_load_n", 16'(n), 16'h0006);
        run(F);

        // Enable mask with hex nibbles.
        do_load(16'hABCD, 4'b0000, 4'b0101);
        run_to_boundary();
        run(F + 1);

        // Randomized traffic.
        repeat (300) begin
            if ($urandom_range(4) == 0) begin
                rv = 16'($urandom);
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(2) == 0) rv[4*b +: 4] = 4'h0;
                do_load(rv, 4'($urandom), 4'($urandom));
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
